// File: rtl/sha256_msg_padder_if.sv
// RAM read port and padded-word stream between the SHA-256 padder and its neighbours.
// master = padder side, slave = RAM / compression-stage side.
interface sha256_msg_padder_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_chipSel;
  logic                  ram_wriEn;
  logic                  ram_outEn;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [31:0]           word_out;
  logic                  word_valid;
  logic                  word_ready;
  logic [3:0]            word_idx;
  logic                  block_last;

  modport master (
    output ram_addr, ram_chipSel, ram_wriEn, ram_outEn,
    output word_out, word_valid, word_idx, block_last,
    input  ram_data, word_ready
  );

  modport slave (
    input  ram_addr, ram_chipSel, ram_wriEn, ram_outEn,
    input  word_out, word_valid, word_idx, block_last,
    output ram_data, word_ready
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: reads message bytes from a registered-read RAM and
// emits the padded stream as big-endian 32-bit words, 16 per 512-bit block.
module sha256_msg_padder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   msg_len,
  output logic                  busy,
  output logic                  done,
  sha256_msg_padder_if.master   bus
);
  // Position counter is wide enough for the padded total (at most 2^ADDR_WIDTH + 72).
  localparam int PW = ADDR_WIDTH + 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;

  state_t                state;
  logic [PW-1:0]         p, len, tot;
  logic [1:0]            bc;
  logic [23:0]           acc;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  cs_q;
  logic [31:0]           word_q;
  logic                  valid_q;
  logic [3:0]            idx_q;
  logic                  last_q;

  logic [PW-1:0] p_inc, len_in, tot_in;
  logic [63:0]   bit_len, bl_sh;
  logic [2:0]    k;
  logic [5:0]    shv;
  logic [7:0]    gen_byte, cur_byte;

  assign bus.ram_addr    = addr_q;
  assign bus.ram_chipSel = cs_q;
  assign bus.ram_outEn   = cs_q;
  assign bus.ram_wriEn   = 1'b0;
  assign bus.word_out    = word_q;
  assign bus.word_valid  = valid_q;
  assign bus.word_idx    = idx_q;
  assign bus.block_last  = last_q;

  always_comb begin
    p_inc   = p + PW'(1);
    len_in  = PW'(msg_len);
    tot_in  = (((len_in + PW'(8)) >> 6) + PW'(1)) << 6;
    bit_len = {{(64-PW-3){1'b0}}, len, 3'b000};
    // Last 8 positions carry 8*L MSB first: position tot-8+k holds byte 7-k.
    k       = 3'(p - (tot - PW'(8)));
    shv     = {3'd7 - k, 3'b000};
    bl_sh   = bit_len >> shv;
    if (p == len)                gen_byte = 8'h80;
    else if (p >= tot - PW'(8))  gen_byte = bl_sh[7:0];
    else                         gen_byte = 8'h00;
    cur_byte = (state == WAIT) ? bus.ram_data[7:0] : gen_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      p       <= '0;
      len     <= '0;
      tot     <= '0;
      bc      <= '0;
      acc     <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      cs_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len   <= len_in;
          tot   <= tot_in;
          p     <= '0;
          bc    <= '0;
          idx_q <= '0;
          busy  <= 1'b1;
          state <= REQ;
          // Read strobe is set on entry so it is visible during the REQ cycle.
          if (len_in != '0) begin
            cs_q   <= 1'b1;
            addr_q <= '0;
          end
        end
        REQ, WAIT: begin
          if (state == REQ && p < len) begin
            state <= WAIT;
          end else begin
            acc <= {acc[15:0], cur_byte};
            p   <= p_inc;
            bc  <= bc + 2'd1;
            if (bc == 2'd3) begin
              word_q  <= {acc, cur_byte};
              valid_q <= 1'b1;
              last_q  <= (p_inc == tot);
              state   <= EMIT;
            end else begin
              state <= REQ;
              if (p_inc < len) begin
                cs_q   <= 1'b1;
                addr_q <= p_inc[ADDR_WIDTH-1:0];
              end
            end
          end
        end
        EMIT: if (valid_q && bus.word_ready) begin
          valid_q <= 1'b0;
          idx_q   <= idx_q + 4'd1;
          if (p == tot) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= REQ;
            if (p < len) begin
              cs_q   <= 1'b1;
              addr_q <= p[ADDR_WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: RAM model, stream monitor and a byte-level
// padding reference built from the plain SHA-256 padding rule.
module tb_sha256_msg_padder;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   msg_len;
  logic          busy, done;

  sha256_msg_padder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) bus ();

  sha256_msg_padder #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [31:0]   exp_q[$];
  logic [31:0]   wq[$];
  logic [3:0]    iq[$];
  logic          lq[$];
  logic [AW-1:0] rq[$];
  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, done_base = 0, done_cyc = 0, last_cyc = 0;
  int bad_ctl = 0, gap = 0, max_gap = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_chipSel && bus.ram_outEn) bus.ram_data <= mem[bus.ram_addr];
  end

  always @(negedge clk) begin
    if (bus.word_valid && bus.word_ready) begin
      wq.push_back(bus.word_out);
      iq.push_back(bus.word_idx);
      lq.push_back(bus.block_last);
      if (bus.block_last) last_cyc = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (bus.ram_chipSel) rq.push_back(bus.ram_addr);
    if (bus.ram_chipSel !== bus.ram_outEn || bus.ram_wriEn !== 1'b0) bad_ctl++;
    if (!busy || bus.word_valid) gap = 0;
    else begin gap++; if (gap > max_gap) max_gap = gap; end
  end

  // Reference: message bytes, 0x80, zeros to 56 mod 64, then 64-bit 8*L big-endian.
  function automatic void build_ref(input int L);
    logic [7:0] q[$];
    logic [63:0] bits;
    bits = 64'(L) * 64'd8;
    exp_q.delete();
    for (int i = 0; i < L; i++) q.push_back(mem[i]);
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int i = 7; i >= 0; i--) q.push_back(8'(bits >> (8*i)));
    for (int i = 0; i < q.size(); i += 4) exp_q.push_back({q[i], q[i+1], q[i+2], q[i+3]});
  endfunction

  task automatic plan_mem();
    for (int i = 0; i < (1<<AW); i++) mem[i] = (i < 30) ? 8'(i) : 8'h00;
  endtask

  task automatic kick(input int L);
    wq.delete(); iq.delete(); lq.delete(); rq.delete();
    done_base = done_cnt;
    @(posedge clk); #1;
    msg_len = (AW+1)'(L);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk); #1;
      if (rnd) bus.word_ready = ($urandom_range(0, 3) != 0);
      if (done_cnt > done_base) begin ok = 1'b1; break; end
    end
    bus.word_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; msg_len = '0; bus.word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, bus.ram_addr, bus.ram_chipSel, bus.ram_outEn, bus.ram_wriEn,
         bus.word_out, bus.word_valid, bus.word_idx, bus.block_last} !== '0) begin
      fails++;
      $display("FAIL reset_outputs busy=%b done=%b addr=%h cs=%b word=%h valid=%b idx=%0d last=%b, want all 0",
               busy, done, bus.ram_addr, bus.ram_chipSel, bus.word_out, bus.word_valid, bus.word_idx, bus.block_last);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_l3();
    bit ok;
    plan_mem(); build_ref(3);
    kick(3); wait_done(1'b0, ok);
    tests++;
    if (!ok || wq.size() != 16) begin fails++; $display("FAIL l3_count ok=%b words=%0d, want 16", ok, wq.size()); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (wq[i] !== exp_q[i] || iq[i] !== 4'(i) || lq[i] !== (i == 15)) begin
        fails++;
        $display("FAIL l3_word[%0d] got %h idx %0d last %b, want %h idx %0d last %b",
                 i, wq[i], iq[i], lq[i], exp_q[i], i, (i == 15));
      end
    end
    tests++;
    if (wq[0] !== 32'h00010280 || wq[15] !== 32'h00000018) begin
      fails++; $display("FAIL l3_known w0=%h w15=%h, want 00010280 00000018", wq[0], wq[15]);
    end
    tests++;
    if (rq.size() != 3 || rq[0] !== 0 || rq[1] !== 1 || rq[2] !== 2) begin
      fails++; $display("FAIL l3_reads count=%0d, want 3 reads at 0,1,2", rq.size());
    end
    tests++;
    if (done_cyc != last_cyc + 1 || busy !== 1'b0) begin
      fails++; $display("FAIL l3_done done_cyc=%0d last_cyc=%0d busy=%b, want done one cycle after last, busy 0",
                        done_cyc, last_cyc, busy);
    end
  endtask

  task automatic test_l30();
    bit ok;
    int errs = 0;
    plan_mem(); build_ref(30);
    kick(30); wait_done(1'b0, ok);
    tests++;
    if (!ok || wq.size() != 16) begin fails++; $display("FAIL l30_count ok=%b words=%0d, want 16", ok, wq.size()); end
    for (int i = 0; i < 16; i++) if (wq[i] !== exp_q[i]) errs++;
    tests++;
    if (errs != 0) begin fails++; $display("FAIL l30_stream %0d words differ, want 0", errs); end
    tests++;
    if (wq[0] !== 32'h00010203 || wq[6] !== 32'h18191A1B || wq[7] !== 32'h1C1D8000 || wq[15] !== 32'h000000F0) begin
      fails++; $display("FAIL l30_known w0=%h w6=%h w7=%h w15=%h, want 00010203 18191a1b 1c1d8000 000000f0",
                        wq[0], wq[6], wq[7], wq[15]);
    end
  endtask

  task automatic test_l56();
    bit ok;
    int errs = 0, nlast = 0;
    plan_mem(); build_ref(56);
    kick(56); wait_done(1'b0, ok);
    tests++;
    if (!ok || wq.size() != 32) begin fails++; $display("FAIL l56_count ok=%b words=%0d, want 32", ok, wq.size()); end
    for (int i = 0; i < 32; i++) begin
      if (wq[i] !== exp_q[i] || iq[i] !== 4'(i)) errs++;
      if (lq[i] === 1'b1) nlast++;
    end
    tests++;
    if (errs != 0) begin fails++; $display("FAIL l56_stream %0d words/idx differ, want 0", errs); end
    tests++;
    if (wq[14] !== 32'h80000000 || wq[31] !== 32'h000001C0 || iq[16] !== 4'd0) begin
      fails++; $display("FAIL l56_known b1w14=%h b2w15=%h idx16=%0d, want 80000000 000001c0 0", wq[14], wq[31], iq[16]);
    end
    tests++;
    if (nlast != 1 || lq[31] !== 1'b1) begin
      fails++; $display("FAIL l56_last count=%0d last31=%b, want 1 and 1", nlast, lq[31]);
    end
  endtask

  task automatic test_l0();
    bit ok;
    int errs = 0;
    plan_mem(); build_ref(0);
    kick(0); wait_done(1'b0, ok);
    tests++;
    if (!ok || wq.size() != 16 || rq.size() != 0) begin
      fails++; $display("FAIL l0_count ok=%b words=%0d reads=%0d, want 16 and 0", ok, wq.size(), rq.size());
    end
    for (int i = 1; i < 16; i++) if (wq[i] !== 32'h0) errs++;
    tests++;
    if (wq[0] !== 32'h80000000 || errs != 0 || wq[0] !== exp_q[0]) begin
      fails++; $display("FAIL l0_words w0=%h nonzero_rest=%0d, want 80000000 and 0", wq[0], errs);
    end
  endtask

  task automatic test_backpressure();
    bit ok, seen = 1'b0;
    int errs = 0;
    plan_mem(); build_ref(30);
    kick(30);
    for (int c = 0; c < 200 && !seen; c++) begin
      if (bus.word_valid && bus.word_idx == 4'd7) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL bp_reach_w7 not reached, want w7 valid"); end
    bus.word_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests++;
      if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h1C1D8000) begin
        fails++; $display("FAIL bp_hold[%0d] valid=%b word=%h, want 1 1c1d8000", c, bus.word_valid, bus.word_out);
      end
    end
    bus.word_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus.word_valid !== 1'b0 || wq.size() != 8) begin
      fails++; $display("FAIL bp_release valid=%b words=%0d, want 0 and 8", bus.word_valid, wq.size());
    end
    wait_done(1'b0, ok);
    for (int i = 0; i < 16; i++) if (wq[i] !== exp_q[i]) errs++;
    tests++;
    if (!ok || wq.size() != 16 || errs != 0) begin
      fails++; $display("FAIL bp_stream ok=%b words=%0d diffs=%0d, want 16 words 0 diffs", ok, wq.size(), errs);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int errs = 0;
    plan_mem();
    kick(56);
    for (int c = 0; c < 300 && wq.size() < 3; c++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({busy, done, bus.ram_addr, bus.ram_chipSel, bus.ram_outEn, bus.word_out,
         bus.word_valid, bus.word_idx, bus.block_last} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs busy=%b addr=%h cs=%b word=%h valid=%b idx=%0d, want all 0",
               busy, bus.ram_addr, bus.ram_chipSel, bus.word_out, bus.word_valid, bus.word_idx);
    end
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    tests++;
    if (done_cnt != done_base || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_nodone dones=%0d busy=%b, want 0 and 0", done_cnt - done_base, busy);
    end
    build_ref(3);
    kick(3);
    repeat (2) @(posedge clk);
    #1;
    msg_len = (AW+1)'(30); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, ok);
    for (int i = 0; i < 16; i++) if (wq[i] !== exp_q[i] || lq[i] !== (i == 15)) errs++;
    tests++;
    if (!ok || wq.size() != 16 || errs != 0 || rq.size() != 3) begin
      fails++; $display("FAIL midrst_rerun ok=%b words=%0d diffs=%0d reads=%0d, want 16 0 3",
                        ok, wq.size(), errs, rq.size());
    end
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (done_cnt != done_base + 1) begin
      fails++; $display("FAIL busy_start_ignored dones=%0d, want 1", done_cnt - done_base);
    end
  endtask

  task automatic test_random();
    int lens[6];
    lens = '{55, 63, 64, 120, 1024, 0};
    lens[5] = $urandom_range(1, 1023);
    for (int r = 0; r < 6; r++) begin
      bit ok;
      int errs = 0, rerr = 0;
      for (int i = 0; i < (1<<AW); i++) mem[i] = 8'($urandom);
      build_ref(lens[r]);
      kick(lens[r]);
      bus.word_ready = 1'b0;
      wait_done(1'b1, ok);
      for (int i = 0; i < exp_q.size(); i++)
        if (wq[i] !== exp_q[i] || iq[i] !== 4'(i) || lq[i] !== (i == exp_q.size() - 1)) errs++;
      for (int i = 0; i < rq.size(); i++) if (rq[i] !== AW'(i)) rerr++;
      tests++;
      if (!ok || wq.size() != exp_q.size() || errs != 0 || rq.size() != lens[r] || rerr != 0) begin
        fails++;
        $display("FAIL rand_L%0d ok=%b words=%0d/%0d diffs=%0d reads=%0d/%0d addr_errs=%0d",
                 lens[r], ok, wq.size(), exp_q.size(), errs, rq.size(), lens[r], rerr);
      end
    end
  endtask

  task automatic test_ctl_latency();
    tests++;
    if (max_gap > 8 || bad_ctl != 0) begin
      fails++; $display("FAIL ctl_latency max_gap=%0d bad_ctl=%0d, want <=8 and 0", max_gap, bad_ctl);
    end
  endtask

  initial begin
    test_reset();
    test_l3();
    test_l30();
    test_l56();
    test_l0();
    test_backpressure();
    test_reset_midrun();
    test_random();
    test_ctl_latency();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
